// File: rtl/cpu_pkg.sv
// Shared constants for the 1-to-4 demultiplexer slice.
//   CP_WIDTH  : default payload width in bits
//   CP_DEPTH  : entries per output-channel FIFO (only 2 is supported)
//   CP_NUM_CH : number of output channels
//   CP_CNT_W  : width of a per-channel occupancy count (holds 0..CP_DEPTH)
package cpu_pkg;
   localparam int CP_WIDTH  = 3;
   localparam int CP_DEPTH  = 2;
   localparam int CP_NUM_CH = 4;
   localparam int CP_CNT_W  = 2;
endpackage : cpu_pkg

// File: rtl/fifo2_3.sv
// Two-entry FIFO used for each demux output channel.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset; clears storage, pointers and count
//   push   : write din this cycle (ignored when full)
//   pop    : drop the head this cycle (ignored when empty)
//   din    : payload to write
//   dout   : head entry, forced to 0 while empty
//   count  : registered occupancy 0..2
module fifo2_3
   import cpu_pkg::*;
#(
   parameter int WIDTH = CP_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  logic [WIDTH-1:0]    din,
   output logic [WIDTH-1:0]    dout,
   output logic [CP_CNT_W-1:0] count
);

   localparam logic [CP_CNT_W-1:0] FULL = CP_CNT_W'(CP_DEPTH);

   logic [WIDTH-1:0]    mem_q [2];
   logic [WIDTH-1:0]    mem_d [2];
   logic                rd_ptr_q, rd_ptr_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic [CP_CNT_W-1:0] count_q, count_d;
   logic                do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q != FULL);
      do_pop   = pop && (count_q != '0);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the count unchanged; the pushed
      // entry lands in the slot the read pointer advances to.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule : fifo2_3

// File: rtl/demux1_4_3.sv
// 1-to-4 demultiplexer with a 2-entry FIFO per output channel.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload until then and the consumer may
// raise ready at any time. in_ready depends only on in_sel and registered
// occupancy, never on out_ready.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   in_data, in_sel   : payload and destination channel 0..3
//   in_valid/in_ready : input handshake
//   o0..o3            : head entry of each channel (0 while empty)
//   out_valid         : bit k set when channel k holds an entry
//   out_ready         : bit k set when the consumer of channel k takes its head
//   busy              : any channel non-empty
module demux1_4_3
   import cpu_pkg::*;
#(
   parameter int WIDTH = CP_WIDTH,
   parameter int DEPTH = CP_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic             busy
);

   localparam logic [CP_CNT_W-1:0] FULL = CP_CNT_W'(DEPTH);

   logic [CP_CNT_W-1:0] cnt  [CP_NUM_CH];
   logic [WIDTH-1:0]    head [CP_NUM_CH];
   logic [3:0]          push;
   logic [3:0]          pop;

   assign in_ready = (cnt[in_sel] != FULL);

   for (genvar k = 0; k < CP_NUM_CH; k++) begin : g_ch
      assign push[k]      = in_valid && in_ready && (in_sel == 2'(k));
      assign out_valid[k] = (cnt[k] != '0);
      assign pop[k]       = out_valid[k] && out_ready[k];

      fifo2_3 #(
         .WIDTH (WIDTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[k]),
         .pop   (pop[k]),
         .din   (in_data),
         .dout  (head[k]),
         .count (cnt[k])
      );
   end

   assign o0   = head[0];
   assign o1   = head[1];
   assign o2   = head[2];
   assign o3   = head[3];
   assign busy = |out_valid;

endmodule : demux1_4_3

// File: tb/tb_demux1_4_3.sv
module tb_demux1_4_3;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o0, o1, o2, o3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per channel, capacity 2.
  logic [W-1:0] exp_q [4][$];

  demux1_4_3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_head(int k);
    return (exp_q[k].size() > 0) ? exp_q[k][0] : '0;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (exp_q[k].size() > 0);
    return v;
  endfunction

  function automatic logic [W-1:0] dut_head(int k);
    case (k)
      0: return o0;
      1: return o1;
      2: return o2;
      default: return o3;
    endcase
  endfunction

  // One rising edge; the model consumes the inputs present at that edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      acc = in_valid && (exp_q[in_sel].size() < 2);
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_front());
      if (acc) exp_q[in_sel].push_back(in_data);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'b0000;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [W-1:0] data);
    in_valid = 1'b1; in_sel = sel; in_data = data;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if ({o0, o1, o2, o3} !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got o=%h/%h/%h/%h busy=%b exp 0", o0, o1, o2, o3, busy);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_one(2'd2, 3'd5);
    checks++;
    if (out_valid !== 4'b0100 || o2 !== 3'd5 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_route got ov=%b o2=%0d busy=%b exp ov=0100 o2=5 busy=1", out_valid, o2, busy);
    end
  endtask

  task automatic test_full();
    do_reset();
    push_one(2'd1, 3'd1);
    push_one(2'd1, 3'd6);
    in_sel = 2'd1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_in_ready_sel1 got=%b exp=0", in_ready);
    end
    in_sel = 2'd3; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL full_in_ready_sel3 got=%b exp=1", in_ready);
    end
    checks++;
    if (o1 !== 3'd1) begin
      failures++; $display("FAIL full_head0 got=%0d exp=1", o1);
    end
    out_ready = 4'b0010;
    tick();
    checks++;
    if (o1 !== 3'd6 || out_valid[1] !== 1'b1) begin
      failures++; $display("FAIL full_head1 got=%0d v=%b exp=6 v=1", o1, out_valid[1]);
    end
    tick();
    checks++;
    if (out_valid[1] !== 1'b0 || o1 !== 3'd0) begin
      failures++; $display("FAIL full_empty got v=%b o1=%0d exp v=0 o1=0", out_valid[1], o1);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_push_pop_same();
    do_reset();
    push_one(2'd0, 3'd3);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 3'd7; out_ready = 4'b0001;
    tick();
    idle();
    checks++;
    if (o0 !== 3'd7 || out_valid[0] !== 1'b1) begin
      failures++; $display("FAIL push_pop_same got o0=%0d v=%b exp o0=7 v=1", o0, out_valid[0]);
    end
    out_ready = 4'b0001;
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++; $display("FAIL push_pop_drain got v=%b exp=0", out_valid[0]);
    end
    out_ready = 4'b0000;
  endtask

  task automatic test_all_channels();
    do_reset();
    for (int k = 0; k < 4; k++) push_one(2'(k), 3'(k + 1));
    checks++;
    if (out_valid !== 4'b1111 || o0 !== 3'd1 || o1 !== 3'd2 || o2 !== 3'd3 || o3 !== 3'd4) begin
      failures++; $display("FAIL all_fill got ov=%b o=%0d,%0d,%0d,%0d exp 1111 1,2,3,4", out_valid, o0, o1, o2, o3);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL all_drain got ov=%b busy=%b exp 0000 0", out_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_one(2'd3, 3'd2);
    push_one(2'd3, 3'd5);
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd3; in_data = 3'd6;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b0000 || o3 !== 3'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset got ov=%b o3=%0d rdy=%b exp 0000 0 1", out_valid, o3, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got_q[$];
    int seq [6] = '{0, 1, 2, 0, 3, 1};
    do_reset();
    out_ready = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sel = 2'(seq[i]); in_data = 3'(seq[i]); #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL sweep_in_ready step=%0d got=%b exp=1", i, in_ready);
      end
      if (out_valid[0]) got_q.push_back(o0);
      tick();
    end
    in_valid = 1'b0;
    if (out_valid[0]) got_q.push_back(o0);
    tick();
    out_ready = 4'b0000;
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 3'd0 || got_q[1] !== 3'd0) begin
      failures++; $display("FAIL sweep_ch0 got n=%0d exp two zeros", got_q.size());
    end
    checks++;
    if (out_valid !== 4'b1110 || o1 !== 3'd1 || o2 !== 3'd2 || o3 !== 3'd3) begin
      failures++; $display("FAIL sweep_hold got ov=%b o=%0d,%0d,%0d exp 1110 1,2,3", out_valid, o1, o2, o3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 3'($urandom_range(0, 7));
      out_ready = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (in_ready !== (exp_q[in_sel].size() < 2)) begin
        failures++; $display("FAIL rand_in_ready cyc=%0d sel=%0d got=%b exp=%b", i, in_sel, in_ready, exp_q[in_sel].size() < 2);
      end
      tick();
      checks++;
      if (out_valid !== exp_valid() || busy !== (|exp_valid())) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b busy=%b exp=%b", i, out_valid, busy, exp_valid());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_head(k) !== exp_head(k)) begin
          failures++; $display("FAIL rand_head cyc=%0d ch=%0d got=%0d exp=%0d", i, k, dut_head(k), exp_head(k));
        end
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_push_pop_same();
    test_all_channels();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux1_4_3.md
DEMUX1_4_3 -- requirements
Module: demux1_4_3

Interface
REQ-001 SHALL have parameter WIDTH, default 3, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output-channel FIFO; only 2 is supported.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_data  input  WIDTH  payload to route.
REQ-006 SHALL have port in_sel  input  2  destination channel index 0..3.
REQ-007 SHALL have port in_valid  input  1  payload and sel valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts the payload this cycle.
REQ-009 SHALL have ports o0, o1, o2, o3  output  WIDTH each  head entry of channels 0..3.
REQ-010 SHALL have port out_valid  output  4  bit k set means channel k holds at least one entry.
REQ-011 SHALL have port out_ready  input  4  bit k set means the consumer of channel k takes the head.
REQ-012 SHALL have port busy  output  1  OR of all out_valid bits.

Function
REQ-013 SHALL accept a payload on a rising clk edge when in_valid=1 and in_ready=1, and push {in_data} into the FIFO of channel in_sel.
REQ-014 SHALL drive in_ready = NOT full[in_sel], combinational from in_sel and registered occupancy only, with no path from out_ready.
REQ-015 SHALL pop the channel-k head on a rising edge when out_valid[k]=1 and out_ready[k]=1.
REQ-016 SHALL make an accepted payload visible on ok with out_valid[k]=1 exactly one cycle after acceptance; latency is 1 cycle and there is no bypass.
REQ-017 SHALL preserve FIFO order within each channel; the four channels are independent and may pop in the same cycle.
REQ-018 SHALL handle push and pop on the same channel in one cycle at occupancy 1 as occupancy 1, with the new entry at head next cycle.
REQ-019 SHALL ignore pops on an empty channel; out_valid[k]=0 and ok=0 while channel k is empty.
REQ-020 SHALL never push when the channel is at occupancy 2; in_ready is low and in_valid is held by the source.
REQ-021 SHALL allow in_sel and in_data to change freely while in_ready=0; the block latches only on acceptance.
REQ-022 SHALL track occupancy per channel as a 2-bit count 0..2 and use a 1-bit read pointer and 1-bit write pointer that wrap modulo 2.
REQ-023 SHALL keep o0..o3, out_valid, in_ready, and busy free of X after the first reset cycle.

Reset
REQ-024 SHALL, when rst_n=0 at a rising edge, clear all counts and pointers and all storage to 0, so that out_valid=4'b0000, o0..o3=0, and busy=0.
REQ-025 SHALL drive in_ready from the empty state (1) in the cycle after reset, regardless of in_sel.
REQ-026 SHALL discard all FIFO contents when reset is asserted mid-operation, and SHALL ignore a simultaneous in_valid in that cycle.

Structure
REQ-027 SHALL place WIDTH default, DEPTH, and the channel-count constant (4) in shared package cpu_pkg.
REQ-028 SHALL instantiate four copies of one sub-module fifo2_3 (2-entry FIFO, clk/rst_n, push/pop/data/count); the top is an index decoder plus glue.

Verification
REQ-029 SHALL cover: reset, then out_ready=4'b0000 and accept in_data=5 with in_sel=2 -> next cycle out_valid=4'b0100, o2=5, and busy=1.
REQ-030 SHALL cover: push 1 then 6 to channel 1 with out_ready=0 -> in_ready=0 when in_sel=1 and 1 when in_sel=3; pop twice -> o1 shows 1, then 6, then out_valid[1]=0.
REQ-031 SHALL cover: channel 0 holding 3 with in_sel=0, in_data=7, in_valid=1, out_ready[0]=1 in the same cycle -> next cycle o0=7 and out_valid[0]=1.
REQ-032 SHALL cover: push 1, 2, 3, 4 to channels 0, 1, 2, 3 -> out_valid=4'b1111; out_ready=4'b1111 for one cycle -> out_valid=4'b0000 and busy=0.
REQ-033 SHALL cover: two entries in channel 3, then rst_n=0 for one cycle with in_valid=1 and in_sel=3 -> out_valid=4'b0000, o3=0, and in_ready=1.
REQ-034 SHALL cover: out_ready=4'b0001 while in_sel sweeps 0,1,2,0,3,1 with in_data equal to the index -> channel 0 delivers 0, 0 in order, and the other channels each hold their own index.
